hier_node_dispatch: RTL and testbench

- Parametrised hierarchy node that connects one upstream request/response port to NUM_CHILDREN downstream child ports.
- Routes each upstream request to the child selected by its destination field.
- Merges child responses back upstream through a round-robin arbiter.
- Tracks outstanding transactions per child and throttles any child that is saturated.
- Replaces fixed-fanout structural nodes in generated module trees.

---
 rtl/hier_node_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/hier_node_dispatch.sv | 159 +++++++++++++++
 tb/tb_hier_node_dispatch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// Shared types and helpers for hierarchy node blocks.
package hier_node_pkg;

   // Upper bound on fanout of a single node.
   localparam int MAX_CHILDREN = 16;

   // Per-child outstanding transaction counter.
   typedef logic [3:0] outst_cnt_t;

   // Index width for n children; a single child still needs one bit.
   function automatic int sel_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority starts one past the last granted
// requester. The pointer moves only when the caller strobes advance.
module rr_arbiter
   import hier_node_pkg::*;
#(
   parameter int N     = 5,
   parameter int IDX_W = sel_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   // Index of the requester currently holding highest priority.
   logic [IDX_W-1:0] r_ptr;

   // Scan requesters starting at the pointer, wrapping at N.
   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(r_ptr) + k;
         if (j >= N) j = j - N;
         if (!grant_any && req[j]) begin
            grant_any = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

   // Move priority to the requester after the one just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (advance && grant_any) begin
         if (int'(grant_idx) == N - 1) r_ptr <= '0;
         else                          r_ptr <= grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/hier_node_dispatch.sv
// Hierarchy node: routes upstream requests to one of NUM_CHILDREN children,
// merges child responses upstream round-robin, and throttles saturated
// children using per-child outstanding counters.
module hier_node_dispatch
   import hier_node_pkg::*;
#(
   parameter int NUM_CHILDREN = 5,
   parameter int DATA_W       = 32,
   parameter int MAX_OUTST    = 4,
   parameter int SEL_W        = sel_width(NUM_CHILDREN)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           up_req_valid,
   output logic                           up_req_ready,
   input  logic [SEL_W-1:0]               up_req_dst,
   input  logic [DATA_W-1:0]              up_req_data,
   output logic [NUM_CHILDREN-1:0]        dn_req_valid,
   input  logic [NUM_CHILDREN-1:0]        dn_req_ready,
   output logic [NUM_CHILDREN*DATA_W-1:0] dn_req_data,
   input  logic [NUM_CHILDREN-1:0]        dn_rsp_valid,
   output logic [NUM_CHILDREN-1:0]        dn_rsp_ready,
   input  logic [NUM_CHILDREN*DATA_W-1:0] dn_rsp_data,
   output logic                           up_rsp_valid,
   input  logic                           up_rsp_ready,
   output logic [DATA_W-1:0]              up_rsp_data,
   output logic [SEL_W-1:0]               up_rsp_src,
   output logic                           busy,
   output logic                           err_bad_dst,
   output logic                           err_unexp_rsp
);

   // Request register (shared by all children).
   logic                r_req_valid;
   logic [SEL_W-1:0]    r_req_dst;
   logic [DATA_W-1:0]   r_req_data;
   // Response register.
   logic                r_rsp_valid;
   logic [SEL_W-1:0]    r_rsp_src;
   logic [DATA_W-1:0]   r_rsp_data;
   // Outstanding counters and error pulses.
   outst_cnt_t [NUM_CHILDREN-1:0] r_outst;
   outst_cnt_t [NUM_CHILDREN-1:0] w_outst_next;
   logic                r_err_bad_dst;
   logic                r_err_unexp;

   logic                    w_dst_ok;
   logic                    w_req_accept;
   logic                    w_req_fire;
   logic [NUM_CHILDREN-1:0] w_inc;
   logic [NUM_CHILDREN-1:0] w_dec;
   logic [NUM_CHILDREN-1:0] w_unexp;
   logic [NUM_CHILDREN-1:0] w_gnt;
   logic [SEL_W-1:0]        w_gnt_idx;
   logic                    w_gnt_any;
   logic                    w_rsp_space;
   logic                    w_rsp_load;
   logic [DATA_W-1:0]       w_rsp_mux;

   // ---------------- request path ----------------
   assign w_dst_ok     = int'(up_req_dst) < NUM_CHILDREN;
   assign w_req_fire   = |w_inc;
   assign up_req_ready = !r_req_valid || w_req_fire;
   assign w_req_accept = up_req_valid && up_req_ready;
   // Every slice carries the payload; only the selected valid qualifies it.
   assign dn_req_data  = {NUM_CHILDREN{r_req_data}};

   // ---------------- response path ----------------
   assign w_rsp_space  = !r_rsp_valid || up_rsp_ready;
   assign w_rsp_load   = w_gnt_any && w_rsp_space;
   assign dn_rsp_ready = w_rsp_space ? w_gnt : '0;

   rr_arbiter #(
      .N     (NUM_CHILDREN),
      .IDX_W (SEL_W)
   ) u_rsp_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (dn_rsp_valid),
      .advance   (w_rsp_load),
      .grant     (w_gnt),
      .grant_idx (w_gnt_idx),
      .grant_any (w_gnt_any)
   );

   // Select the granted child's payload with a one-hot AND-OR mux.
   always_comb begin
      w_rsp_mux = '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         if (w_gnt[i]) w_rsp_mux = w_rsp_mux | dn_rsp_data[i*DATA_W +: DATA_W];
      end
   end

   // Per-child valid gating and counter update.
   generate
      for (genvar gi = 0; gi < NUM_CHILDREN; gi++) begin : g_child
         assign dn_req_valid[gi] = r_req_valid && (r_req_dst == SEL_W'(gi))
                                   && (r_outst[gi] != outst_cnt_t'(MAX_OUTST));
         assign w_inc[gi]   = dn_req_valid[gi] && dn_req_ready[gi];
         assign w_dec[gi]   = w_rsp_load && w_gnt[gi];
         assign w_unexp[gi] = w_dec[gi] && (r_outst[gi] == '0);
         assign w_outst_next[gi] =
            (w_inc[gi] && !w_dec[gi])                          ? r_outst[gi] + outst_cnt_t'(1) :
            (w_dec[gi] && !w_inc[gi] && r_outst[gi] != '0)     ? r_outst[gi] - outst_cnt_t'(1) :
                                                                 r_outst[gi];
      end
   endgenerate

   // Request register: load on good accept, clear when the child takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_valid <= 1'b0;
         r_req_dst   <= '0;
         r_req_data  <= '0;
      end else if (w_req_accept && w_dst_ok) begin
         r_req_valid <= 1'b1;
         r_req_dst   <= up_req_dst;
         r_req_data  <= up_req_data;
      end else if (w_req_fire) begin
         r_req_valid <= 1'b0;
      end
   end

   // Response register: load arbiter winner, clear when upstream drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_src   <= '0;
         r_rsp_data  <= '0;
      end else if (w_rsp_load) begin
         r_rsp_valid <= 1'b1;
         r_rsp_src   <= w_gnt_idx;
         r_rsp_data  <= w_rsp_mux;
      end else if (up_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Outstanding counters and single-cycle error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst       <= '0;
         r_err_bad_dst <= 1'b0;
         r_err_unexp   <= 1'b0;
      end else begin
         r_outst       <= w_outst_next;
         r_err_bad_dst <= w_req_accept && !w_dst_ok;
         r_err_unexp   <= |w_unexp;
      end
   end

   assign up_rsp_valid  = r_rsp_valid;
   assign up_rsp_data   = r_rsp_data;
   assign up_rsp_src    = r_rsp_src;
   assign err_bad_dst   = r_err_bad_dst;
   assign err_unexp_rsp = r_err_unexp;
   assign busy          = (|r_outst) || r_req_valid || r_rsp_valid;

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Directed bench for hier_node_dispatch (5 children, 32-bit data, 4 outstanding).
module tb_hier_node_dispatch;

   localparam int NC = 5;
   localparam int DW = 32;
   localparam int SW = 3;

   logic            clk;
   logic            rst_n;
   logic            up_req_valid;
   logic            up_req_ready;
   logic [SW-1:0]   up_req_dst;
   logic [DW-1:0]   up_req_data;
   logic [NC-1:0]   dn_req_valid;
   logic [NC-1:0]   dn_req_ready;
   logic [NC*DW-1:0] dn_req_data;
   logic [NC-1:0]   dn_rsp_valid;
   logic [NC-1:0]   dn_rsp_ready;
   logic [NC*DW-1:0] dn_rsp_data;
   logic            up_rsp_valid;
   logic            up_rsp_ready;
   logic [DW-1:0]   up_rsp_data;
   logic [SW-1:0]   up_rsp_src;
   logic            busy;
   logic            err_bad_dst;
   logic            err_unexp_rsp;

   int n_pass  = 0;
   int n_total = 0;

   hier_node_dispatch #(
      .NUM_CHILDREN (NC),
      .DATA_W       (DW),
      .MAX_OUTST    (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .up_req_valid  (up_req_valid),
      .up_req_ready  (up_req_ready),
      .up_req_dst    (up_req_dst),
      .up_req_data   (up_req_data),
      .dn_req_valid  (dn_req_valid),
      .dn_req_ready  (dn_req_ready),
      .dn_req_data   (dn_req_data),
      .dn_rsp_valid  (dn_rsp_valid),
      .dn_rsp_ready  (dn_rsp_ready),
      .dn_rsp_data   (dn_rsp_data),
      .up_rsp_valid  (up_rsp_valid),
      .up_rsp_ready  (up_rsp_ready),
      .up_rsp_data   (up_rsp_data),
      .up_rsp_src    (up_rsp_src),
      .busy          (busy),
      .err_bad_dst   (err_bad_dst),
      .err_unexp_rsp (err_unexp_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      up_req_valid = 1'b0; up_req_dst = '0; up_req_data = '0;
      dn_req_ready = '1;   dn_rsp_valid = '0; dn_rsp_data = '0;
      up_rsp_ready = 1'b1;
      do_reset();
      n_total++; if (dn_req_valid !== 5'b0) $display("FAIL reset_dn_req_valid got=%b exp=%b", dn_req_valid, 5'b0); else n_pass++;
      n_total++; if (up_rsp_valid !== 1'b0) $display("FAIL reset_up_rsp_valid got=%b exp=0", up_rsp_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (up_req_ready !== 1'b1) $display("FAIL reset_up_req_ready got=%b exp=1", up_req_ready); else n_pass++;
      n_total++; if ({err_bad_dst, err_unexp_rsp} !== 2'b00) $display("FAIL reset_err got=%b exp=00", {err_bad_dst, err_unexp_rsp}); else n_pass++;
   endtask

   task automatic test_basic();
      up_req_valid = 1'b1; up_req_dst = 3'd2; up_req_data = 32'hA5A5_0001;
      #1;
      n_total++; if (up_req_ready !== 1'b1) $display("FAIL basic_accept got=%b exp=1", up_req_ready); else n_pass++;
      tick();
      up_req_valid = 1'b0;
      n_total++; if (dn_req_valid !== 5'b00100) $display("FAIL basic_dn_valid got=%b exp=%b", dn_req_valid, 5'b00100); else n_pass++;
      n_total++; if (dn_req_data[2*DW +: DW] !== 32'hA5A5_0001) $display("FAIL basic_dn_data got=%h exp=a5a50001", dn_req_data[2*DW +: DW]); else n_pass++;
      tick();
      n_total++; if (dut.r_outst[2] !== 4'd1) $display("FAIL basic_outst_inc got=%0d exp=1", dut.r_outst[2]); else n_pass++;
      n_total++; if (dn_req_valid !== 5'b0) $display("FAIL basic_dn_clear got=%b exp=0", dn_req_valid); else n_pass++;
      dn_rsp_valid = 5'b00100; dn_rsp_data[2*DW +: DW] = 32'h0000_1234;
      #1;
      n_total++; if (dn_rsp_ready !== 5'b00100) $display("FAIL basic_rsp_ready got=%b exp=%b", dn_rsp_ready, 5'b00100); else n_pass++;
      tick();
      dn_rsp_valid = '0;
      $display("basic rsp: valid=%b src=%0d data=%h", up_rsp_valid, up_rsp_src, up_rsp_data);
      n_total++; if (up_rsp_valid !== 1'b1) $display("FAIL basic_up_rsp_valid got=%b exp=1", up_rsp_valid); else n_pass++;
      n_total++; if (up_rsp_src !== 3'd2) $display("FAIL basic_up_rsp_src got=%0d exp=2", up_rsp_src); else n_pass++;
      n_total++; if (up_rsp_data !== 32'h0000_1234) $display("FAIL basic_up_rsp_data got=%h exp=00001234", up_rsp_data); else n_pass++;
      n_total++; if (dut.r_outst[2] !== 4'd0) $display("FAIL basic_outst_dec got=%0d exp=0", dut.r_outst[2]); else n_pass++;
      n_total++; if (err_unexp_rsp !== 1'b0) $display("FAIL basic_no_unexp got=%b exp=0", err_unexp_rsp); else n_pass++;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         up_req_valid = 1'b1; up_req_dst = 3'd0; up_req_data = 32'h100 + k;
         #1;
         n_total++; if (up_req_ready !== 1'b1) $display("FAIL sat_accept%0d got=%b exp=1", k, up_req_ready); else n_pass++;
         tick();
         $display("sat req %0d sent, outst0=%0d", k, dut.r_outst[0]);
      end
      up_req_valid = 1'b0;
      tick(); tick();
      n_total++; if (dut.r_outst[0] !== 4'd4) $display("FAIL sat_outst_full got=%0d exp=4", dut.r_outst[0]); else n_pass++;
      n_total++; if (dn_req_valid !== 5'b0) $display("FAIL sat_held_valid got=%b exp=0", dn_req_valid); else n_pass++;
      n_total++; if (up_req_ready !== 1'b0) $display("FAIL sat_up_ready got=%b exp=0", up_req_ready); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL sat_busy got=%b exp=1", busy); else n_pass++;
      dn_rsp_valid = 5'b00001; dn_rsp_data[0 +: DW] = 32'h55;
      tick();
      dn_rsp_valid = '0;
      n_total++; if (dn_req_valid !== 5'b00001) $display("FAIL sat_fifth_issue got=%b exp=00001", dn_req_valid); else n_pass++;
      n_total++; if (dn_req_data[0 +: DW] !== 32'h104) $display("FAIL sat_fifth_data got=%h exp=104", dn_req_data[0 +: DW]); else n_pass++;
      tick();
      n_total++; if (dut.r_outst[0] !== 4'd4) $display("FAIL sat_refill got=%0d exp=4", dut.r_outst[0]); else n_pass++;
      dn_rsp_valid = 5'b00001;
      for (int k = 0; k < 4; k++) tick();
      dn_rsp_valid = '0;
      n_total++; if (dut.r_outst[0] !== 4'd0) $display("FAIL sat_drain_outst got=%0d exp=0", dut.r_outst[0]); else n_pass++;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL sat_drain_busy got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_bad_dst();
      up_req_valid = 1'b1; up_req_dst = 3'd7; up_req_data = 32'hDEAD_0007;
      #1;
      n_total++; if (up_req_ready !== 1'b1) $display("FAIL bad_accept got=%b exp=1", up_req_ready); else n_pass++;
      tick();
      up_req_valid = 1'b0;
      $display("bad dst: err=%b dn_valid=%b", err_bad_dst, dn_req_valid);
      n_total++; if (err_bad_dst !== 1'b1) $display("FAIL bad_err_pulse got=%b exp=1", err_bad_dst); else n_pass++;
      n_total++; if (dn_req_valid !== 5'b0) $display("FAIL bad_no_valid got=%b exp=0", dn_req_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL bad_busy got=%b exp=0", busy); else n_pass++;
      tick();
      n_total++; if (err_bad_dst !== 1'b0) $display("FAIL bad_err_clear got=%b exp=0", err_bad_dst); else n_pass++;
   endtask

   task automatic test_arbitration();
      logic [SW-1:0] exp_src [6];
      exp_src = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
      do_reset();
      for (int i = 0; i < NC; i++) dn_rsp_data[i*DW +: DW] = 32'hC0 + i;
      dn_rsp_valid = 5'b01011;
      for (int k = 0; k < 6; k++) begin
         tick();
         $display("arb grant %0d: src=%0d data=%h", k, up_rsp_src, up_rsp_data);
         n_total++; if (up_rsp_src !== exp_src[k]) $display("FAIL arb_src%0d got=%0d exp=%0d", k, up_rsp_src, exp_src[k]); else n_pass++;
         n_total++; if (up_rsp_data !== 32'hC0 + 32'(exp_src[k])) $display("FAIL arb_data%0d got=%h exp=%h", k, up_rsp_data, 32'hC0 + 32'(exp_src[k])); else n_pass++;
      end
      dn_rsp_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      up_rsp_ready = 1'b0;
      dn_rsp_valid = 5'b10000; dn_rsp_data[4*DW +: DW] = 32'h0000_BEEF;
      #1;
      n_total++; if (dn_rsp_ready !== 5'b10000) $display("FAIL bp_ready_empty got=%b exp=10000", dn_rsp_ready); else n_pass++;
      tick();
      n_total++; if (up_rsp_valid !== 1'b1 || up_rsp_src !== 3'd4) $display("FAIL bp_load got=%b/%0d exp=1/4", up_rsp_valid, up_rsp_src); else n_pass++;
      n_total++; if (err_unexp_rsp !== 1'b1) $display("FAIL bp_unexp_pulse got=%b exp=1", err_unexp_rsp); else n_pass++;
      held = up_rsp_data;
      n_total++; if (held !== 32'h0000_BEEF) $display("FAIL bp_data got=%h exp=0000beef", held); else n_pass++;
      dn_rsp_valid = 5'b10010;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_total++; if (up_rsp_data !== 32'h0000_BEEF || up_rsp_valid !== 1'b1) $display("FAIL bp_hold%0d got=%h exp=0000beef", k, up_rsp_data); else n_pass++;
         n_total++; if (dn_rsp_ready !== 5'b0) $display("FAIL bp_ready%0d got=%b exp=0", k, dn_rsp_ready); else n_pass++;
         n_total++; if (err_unexp_rsp !== 1'b0) $display("FAIL bp_unexp_once%0d got=%b exp=0", k, err_unexp_rsp); else n_pass++;
      end
      dn_rsp_valid = '0;
      up_rsp_ready = 1'b1;
      tick();
      n_total++; if (up_rsp_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", up_rsp_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) begin
         up_req_valid = 1'b1; up_req_dst = SW'(k); up_req_data = 32'h200 + k;
         tick();
      end
      up_req_valid = 1'b0;
      tick();
      up_rsp_ready = 1'b0;
      dn_rsp_valid = 5'b01000;
      tick();
      dn_rsp_valid = '0;
      $display("pre-reset: outst=%h rsp_valid=%b busy=%b", dut.r_outst, up_rsp_valid, busy);
      n_total++; if (dut.r_outst !== 20'h00111) $display("FAIL mid_outst_before got=%h exp=00111", dut.r_outst); else n_pass++;
      n_total++; if (up_rsp_valid !== 1'b1) $display("FAIL mid_rsp_before got=%b exp=1", up_rsp_valid); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (up_rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got=%b exp=0", up_rsp_valid); else n_pass++;
      n_total++; if (dut.r_outst !== 20'h0) $display("FAIL mid_outst got=%h exp=0", dut.r_outst); else n_pass++;
      n_total++; if (dn_req_valid !== 5'b0) $display("FAIL mid_dn_valid got=%b exp=0", dn_req_valid); else n_pass++;
      #2;
      rst_n = 1'b1;
      up_rsp_ready = 1'b1;
      dn_rsp_valid = 5'b10101;
      #1;
      n_total++; if (dn_rsp_ready !== 5'b00001) $display("FAIL mid_first_grant got=%b exp=00001", dn_rsp_ready); else n_pass++;
      tick();
      n_total++; if (up_rsp_src !== 3'd0) $display("FAIL mid_first_src got=%0d exp=0", up_rsp_src); else n_pass++;
      dn_rsp_valid = '0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_bad_dst();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
